buf64_rdctl: RTL
================

Name: buf64_rdctl

Overview:
Sequencer for the 2x64 complex ping-pong FFT buffer RAM (one write port, one read port). It accepts a continuous stream of complex samples and writes each 64-sample frame at sequential addresses into one half of the RAM. It reads the previously written half in bit-reversed order and toggles ODD every frame. The RAM read data is re-registered and tagged with frame-start/valid strobes. It sits between the FFT input/stage datapath and the buffer RAM instance.

Parameters:
nb, 16, bit width of each real/imaginary data word.

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  reset, synchronous, active-high
ED  input  1  enable/data-strobe; when 0 all state, counters and pipeline freeze
START  input  1  frame-start pulse; sampled only when ED=1
DR  input  nb  input sample, real part
DI  input  nb  input sample, imaginary part
RAM_DR  output  nb  registered DR toward RAM write data (real)
RAM_DI  output  nb  registered DI toward RAM write data (imaginary)
WE  output  1  RAM write enable
ODD  output  1  RAM half select; writes go to half ~ODD, reads come from half ODD
ADDRW  output  6  RAM write address
ADDRR  output  6  RAM read address
RAM_DOR  input  nb  RAM read data, real; valid 2 ED cycles after ADDRR/ODD are presented
RAM_DOI  input  nb  RAM read data, imaginary; same timing as RAM_DOR
DOR  output  nb  output sample, real
DOI  output  nb  output sample, imaginary
RDY  output  1  one-cycle pulse coincident with output sample 0 of each frame
VLD  output  1  high while DOR/DOI carry valid frame data

Behaviour:
- Reset (RST=1 at clock edge, overrides ED):
  - WE=0, ODD=0, ADDRW=0, ADDRR=0.
  - RAM_DR=RAM_DI=DOR=DOI=0, RDY=0, VLD=0.
  - State goes to IDLE; write counter wc=0, read counter rc=0.
  - All read-pipeline valid flags are cleared.
- States:
  - IDLE: WE=0, no reads.
  - FILL: first frame is being written; no reads.
  - STREAM: write frame k+1 while reading frame k.
- All transitions and all register updates occur only on edges with ED=1.
- IDLE -> FILL on START:
  - The sample on DR/DI in the START cycle is frame sample 0.
  - Next cycle: RAM_DR/RAM_DI = that sample, WE=1, ADDRW=0.
- Write side (FILL and STREAM):
  - wc increments each ED cycle, 0..63, wrapping to 0.
  - RAM_DR/RAM_DI, WE and ADDRW are registered together, so they are always aligned.
- Frame boundary: on the edge where ADDRW goes 63 -> 0, ODD toggles.
  - FILL -> STREAM at the first wrap; STREAM remains in STREAM.
  - At the same edge, rc resets to 0 and read of the just-written half starts.
- Read side (STREAM): ADDRR = bitrev6(rc), i.e. {rc[0],rc[1],...,rc[5]}. ADDRR and ODD change on the same edge.
- Read pipeline:
  - 2-stage ED-qualified valid/first-flag shift register matches the RAM latency.
  - DOR/DOI register RAM_DOR/RAM_DOI when the stage-2 valid is set.
  - VLD follows the stage-2 valid; RDY follows the stage-2 first-flag (rc==0).
- Latency: input sample 0 accepted at ED-cycle c0:
  - written at c0+1;
  - read address 0 issued at c0+65;
  - DOR/DOI sample 0 with RDY=1 at c0+68.
  - Throughput is one sample per ED cycle; VLD stays continuously high once STREAM output starts.
- START in FILL or STREAM:
  - wc=rc=0, ODD=0, state=FILL.
  - Pipeline valid flags cleared, so VLD=0 on the next edge.
  - The START-cycle sample becomes sample 0 of a new first frame; the partial frame is discarded.
- START coincident with wrap: START wins; no ODD toggle.
- ED=0 for any number of cycles: outputs hold, nothing advances, no skipped or duplicated samples.
- WE only ever addresses half ~ODD; read/write collision is impossible by construction.

Optional Feature:
BUF64_BITREV_EN:
- Defined: ADDRR = bitrev6(rc); output is FFT bit-reversed reordering.
- Undefined: ADDRR = rc (natural order); the block is a pure 64-sample frame delay.
- Latency, RDY/VLD timing and ODD behaviour are identical in both builds.

Test Plan:
- Reset: RST=1 for 2 cycles with ED=1 and random DR -> all outputs 0, WE=0, VLD=0.
- Frame 0..63 ramp:
  - Setup: START with DR=n, DI=-n at input n, then continuous ED.
  - BITREV_EN defined: RDY at c0+68; DOR sequence 0,32,16,48,8,...,63.
  - BITREV_EN undefined: DOR sequence 0,1,2,...,63.
- ODD toggling: 3 back-to-back frames -> ODD toggles at c0+65 and c0+129. WE never deasserts. RDY pulses at c0+68 and c0+132, exactly 64 ED cycles apart.
- ED gaps: ED=0 every third cycle during frame 1 -> output sequence identical to the gap-free run; DOR/DOI hold while ED=0.
- START mid-frame: START at write sample 20 of frame 1 -> ODD=0, VLD=0 next edge. The next RDY comes 68 ED cycles after the re-START, carrying the new sample 0.
- Reset mid-STREAM: RST at rc=30 -> all outputs 0 next edge. State IDLE: no WE until a new START.

Source files
------------

// File: rtl/buf64_rdctl.sv
// Ping-pong 2x64 FFT buffer sequencer: writes frames in order, reads the other half back.
// Build option BUF64_BITREV_EN: when defined the read order is bit-reversed, otherwise natural.
module buf64_rdctl #(
  parameter int nb = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ED,
  input  logic          START,
  input  logic [nb-1:0] DR,
  input  logic [nb-1:0] DI,
  output logic [nb-1:0] RAM_DR,
  output logic [nb-1:0] RAM_DI,
  output logic          WE,
  output logic          ODD,
  output logic [5:0]    ADDRW,
  output logic [5:0]    ADDRR,
  input  logic [nb-1:0] RAM_DOR,
  input  logic [nb-1:0] RAM_DOI,
  output logic [nb-1:0] DOR,
  output logic [nb-1:0] DOI,
  output logic          RDY,
  output logic          VLD
);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t            state, state_nxt;
  logic [5:0]        wc, rc;
  logic [STAGES:1]   vld_pipe, frst_pipe;
  logic              wrap, rd_act;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

  // wc already points at the next write slot, so wc==0 means this edge rewrites address 0.
  assign wrap   = (state != IDLE) && (wc == 6'd0);
  assign rd_act = (state == STREAM);

`ifdef BUF64_BITREV_EN
  assign ADDRR = bitrev6(rc);
`else
  assign ADDRR = rc;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ED) begin
      if (START)     state_nxt = FILL;
      else if (wrap) state_nxt = STREAM;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wc        <= '0;
      rc        <= '0;
      ADDRW     <= '0;
      WE        <= 1'b0;
      ODD       <= 1'b0;
      RAM_DR    <= '0;
      RAM_DI    <= '0;
      vld_pipe  <= '0;
      frst_pipe <= '0;
      DOR       <= '0;
      DOI       <= '0;
      VLD       <= 1'b0;
      RDY       <= 1'b0;
    end else if (ED) begin
      if (START) begin
        // Restart always begins a fresh first frame; any partial frame is dropped.
        wc        <= 6'd1;
        rc        <= '0;
        ADDRW     <= '0;
        WE        <= 1'b1;
        ODD       <= 1'b0;
        RAM_DR    <= DR;
        RAM_DI    <= DI;
        vld_pipe  <= '0;
        frst_pipe <= '0;
        VLD       <= 1'b0;
        RDY       <= 1'b0;
      end else begin
        if (state != IDLE) begin
          wc     <= wc + 6'd1;
          ADDRW  <= wc;
          WE     <= 1'b1;
          RAM_DR <= DR;
          RAM_DI <= DI;
        end
        if (wrap) begin
          ODD <= ~ODD;
          rc  <= '0;
        end else if (rd_act) begin
          rc  <= rc + 6'd1;
        end
        vld_pipe  <= {vld_pipe[1], rd_act};
        frst_pipe <= {frst_pipe[1], rd_act && (rc == 6'd0)};
        VLD       <= vld_pipe[STAGES];
        RDY       <= frst_pipe[STAGES];
        if (vld_pipe[STAGES]) begin
          DOR <= RAM_DOR;
          DOI <= RAM_DOI;
        end
      end
    end
  end
endmodule
